// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin two-requester scheduler for a shared ALU and result FIFO (optional ALU_SCHED_STATS_EN adds done0_cnt/done1_cnt)
module alu_op_scheduler #(
  parameter int WIDTH = 8,
  parameter int OPW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_wtag,
  input  logic             fifo_full,
  output logic             busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]      done0_cnt,
  output logic [15:0]      done1_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, tag_q, tag_d, grant1, accept;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0] op_q, op_d;
  always_comb begin
    grant1 = req1_valid && (!req0_valid || ptr_q);
    req0_ready = state_q == IDLE && req0_valid && !grant1;
    req1_ready = state_q == IDLE && grant1;
    accept = req0_ready || req1_ready;
    fifo_wr_en = state_q == WRITE && !fifo_full;
    state_d = accept ? ISSUE : state_q == ISSUE ? WRITE : fifo_wr_en ? IDLE : state_q;
    ptr_d = accept ? !grant1 : ptr_q;
    tag_d = accept ? grant1 : tag_q;
    a_d = accept ? (grant1 ? req1_a : req0_a) : a_q;
    b_d = accept ? (grant1 ? req1_b : req0_b) : b_q;
    op_d = accept ? (grant1 ? req1_op : req0_op) : op_q;
    res_d = state_q == ISSUE ? alu_result : res_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      tag_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign fifo_wdata = res_q;
  assign fifo_wtag = tag_q;
  assign busy = state_q != IDLE;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = fifo_wr_en && !tag_q ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = fifo_wr_en && tag_q ? cnt1_q + 16'd1 : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign done0_cnt = cnt0_q;
  assign done1_cnt = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: scoreboard bench for alu_op_scheduler with a behavioural ALU
module tb_alu_op_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_result, fifo_wdata;
  logic [2:0] alu_op;
  logic fifo_wr_en, fifo_wtag, fifo_full, busy;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] done0_cnt, done1_cnt;
`endif
  int cmp_n = 0;
  int bad_n = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  bit wr_tag[$];
  logic [7:0] wr_data[$];
  int wr_cyc[$];
  bit acc_tag[$];
  int acc_cyc[$];

  alu_op_scheduler #(.WIDTH(8), .OPW(3)) dut (
`ifdef ALU_SCHED_STATS_EN
    .done0_cnt(done0_cnt),
    .done1_cnt(done1_cnt),
`endif
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .req1_op(req1_op),
    .req1_ready(req1_ready),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata),
    .fifo_wtag(fifo_wtag),
    .fifo_full(fifo_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb
    alu_result = alu_op == 3'd0 ? alu_a + alu_b :
                 alu_op == 3'd1 ? alu_a - alu_b :
                 alu_op == 3'd2 ? alu_a & alu_b :
                 alu_op == 3'd3 ? alu_a | alu_b :
                 alu_op == 3'd4 ? alu_a ^ alu_b : alu_a;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && fifo_wr_en) begin
      wr_tag.push_back(fifo_wtag);
      wr_data.push_back(fifo_wdata);
      wr_cyc.push_back(cyc);
    end
    if (!reset && req0_valid && req0_ready) begin
      acc_tag.push_back(1'b0);
      acc_cyc.push_back(cyc);
    end
    if (!reset && req1_valid && req1_ready) begin
      acc_tag.push_back(1'b1);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clk_n(2);
    cmp_n++;
    if ({busy, fifo_wr_en, req0_ready, req1_ready} !== 4'b0000) begin
      bad_n++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, fifo_wr_en, req0_ready, req1_ready});
    end
    cmp_n++;
    if ({fifo_wtag, fifo_wdata, alu_a, alu_b, alu_op} !== 28'h0) begin
      bad_n++;
      $display("FAIL reset_regs got %h want 0", {fifo_wtag, fifo_wdata, alu_a, alu_b, alu_op});
    end
    reset = 1'b0;
    clk_n(1);
  endtask

  task automatic test_single;
    int w0, a0;
    logic [8:0] e;
    w0 = wr_tag.size();
    a0 = acc_tag.size();
    req0_a = 8'h01;
    req0_b = 8'h01;
    req0_op = 3'd0;
    req0_valid = 1'b1;
    exp_q.push_back({1'b0, 8'h02});
    #1;
    cmp_n++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad_n++;
      $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    end
    clk_n(1);
    req0_valid = 1'b0;
    clk_n(3);
    cmp_n++;
    if (wr_tag.size() - w0 !== 1) begin
      bad_n++;
      $display("FAIL single_count got %0d want 1", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL single_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    if (wr_tag.size() > w0 && acc_tag.size() > a0) begin
      cmp_n++;
      if (wr_cyc[w0] - acc_cyc[a0] !== 2) begin
        bad_n++;
        $display("FAIL single_latency got %0d want 2", wr_cyc[w0] - acc_cyc[a0]);
      end
    end
    cmp_n++;
    if ({busy, alu_a, alu_b, alu_op} !== {1'b0, 8'h01, 8'h01, 3'd0}) begin
      bad_n++;
      $display("FAIL single_hold got %h want %h", {busy, alu_a, alu_b, alu_op}, {1'b0, 8'h01, 8'h01, 3'd0});
    end
  endtask

  task automatic test_contention;
    int w0, a0, g;
    logic [8:0] e;
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    w0 = wr_tag.size();
    a0 = acc_tag.size();
    req0_a = 8'h02;
    req0_b = 8'h01;
    req0_op = 3'd1;
    req1_a = 8'hFF;
    req1_b = 8'h0F;
    req1_op = 3'd2;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b1, 8'h0F});
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    g = 0;
    while (acc_tag.size() < a0 + 4 && g < 60) begin
      clk_n(1);
      g++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clk_n(4);
    cmp_n++;
    if (wr_tag.size() - w0 !== 4) begin
      bad_n++;
      $display("FAIL contention_count got %0d want 4", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL contention_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    for (int k = a0 + 1; k < acc_tag.size() && k < a0 + 4; k++) begin
      cmp_n++;
      if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin
        bad_n++;
        $display("FAIL contention_spacing got %0d want 3", acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int w0, a0, g;
    logic [8:0] e;
    w0 = wr_tag.size();
    a0 = acc_tag.size();
    fifo_full = 1'b1;
    req0_a = 8'h03;
    req0_b = 8'h04;
    req0_op = 3'd0;
    req0_valid = 1'b1;
    exp_q.push_back({1'b0, 8'h07});
    exp_q.push_back({1'b1, 8'h00});
    clk_n(1);
    req0_valid = 1'b0;
    req1_a = 8'h05;
    req1_b = 8'h05;
    req1_op = 3'd4;
    req1_valid = 1'b1;
    clk_n(1);
    for (int i = 0; i < 4; i++) begin
      cmp_n++;
      if ({fifo_wr_en, req1_ready, fifo_wtag, fifo_wdata} !== {3'b000, 8'h07}) begin
        bad_n++;
        $display("FAIL stall_hold got %h want %h", {fifo_wr_en, req1_ready, fifo_wtag, fifo_wdata}, {3'b000, 8'h07});
      end
      clk_n(1);
    end
    cmp_n++;
    if (acc_tag.size() - a0 !== 1) begin
      bad_n++;
      $display("FAIL stall_accepts got %0d want 1", acc_tag.size() - a0);
    end
    fifo_full = 1'b0;
    #1;
    cmp_n++;
    if (fifo_wr_en !== 1'b1) begin
      bad_n++;
      $display("FAIL stall_release got %b want 1", fifo_wr_en);
    end
    g = 0;
    while (acc_tag.size() < a0 + 2 && g < 20) begin
      clk_n(1);
      g++;
    end
    req1_valid = 1'b0;
    clk_n(4);
    cmp_n++;
    if (wr_tag.size() - w0 !== 2) begin
      bad_n++;
      $display("FAIL stall_count got %0d want 2", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL stall_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int w0;
    logic [8:0] e;
    w0 = wr_tag.size();
    req0_a = 8'h09;
    req0_b = 8'h01;
    req0_op = 3'd0;
    req0_valid = 1'b1;
    clk_n(1);
    req0_valid = 1'b0;
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    cmp_n++;
    if (busy !== 1'b0) begin
      bad_n++;
      $display("FAIL mid_busy got %b want 0", busy);
    end
    clk_n(3);
    cmp_n++;
    if (wr_tag.size() - w0 !== 0) begin
      bad_n++;
      $display("FAIL mid_nowrite got %0d want 0", wr_tag.size() - w0);
    end
    req1_a = 8'h11;
    req1_b = 8'h22;
    req1_op = 3'd3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_q.push_back({1'b0, 8'h0A});
    #1;
    cmp_n++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad_n++;
      $display("FAIL mid_grant got %b want 10", {req0_ready, req1_ready});
    end
    clk_n(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clk_n(3);
    cmp_n++;
    if (wr_tag.size() - w0 !== 1) begin
      bad_n++;
      $display("FAIL mid_count got %0d want 1", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL mid_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_lone_fairness;
    int w0, a0, g;
    logic [8:0] e;
    w0 = wr_tag.size();
    a0 = acc_tag.size();
    req1_a = 8'h10;
    req1_b = 8'h03;
    req1_op = 3'd3;
    req0_a = 8'h20;
    req0_b = 8'h22;
    req0_op = 3'd4;
    repeat (3) exp_q.push_back({1'b1, 8'h13});
    exp_q.push_back({1'b0, 8'h02});
    req1_valid = 1'b1;
    g = 0;
    while (acc_tag.size() < a0 + 3 && g < 40) begin
      clk_n(1);
      g++;
    end
    req0_valid = 1'b1;
    g = 0;
    while (acc_tag.size() < a0 + 4 && g < 20) begin
      clk_n(1);
      g++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clk_n(4);
    cmp_n++;
    if (acc_tag.size() - a0 !== 4) begin
      bad_n++;
      $display("FAIL lone_accepts got %0d want 4", acc_tag.size() - a0);
    end
    cmp_n++;
    if (wr_tag.size() - w0 !== 4) begin
      bad_n++;
      $display("FAIL lone_count got %0d want 4", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL lone_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    exp_q.delete();
  endtask

`ifdef ALU_SCHED_STATS_EN
  task automatic test_stats;
    int w0, a0, g;
    logic [8:0] e;
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    w0 = wr_tag.size();
    a0 = acc_tag.size();
    req0_a = 8'h01;
    req0_b = 8'h02;
    req0_op = 3'd0;
    req1_a = 8'h07;
    req1_b = 8'h02;
    req1_op = 3'd1;
    repeat (5) exp_q.push_back({1'b0, 8'h03});
    repeat (3) exp_q.push_back({1'b1, 8'h05});
    req0_valid = 1'b1;
    g = 0;
    while (acc_tag.size() < a0 + 5 && g < 60) begin
      clk_n(1);
      g++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    g = 0;
    while (acc_tag.size() < a0 + 8 && g < 60) begin
      clk_n(1);
      g++;
    end
    req1_valid = 1'b0;
    clk_n(4);
    cmp_n++;
    if ({done0_cnt, done1_cnt} !== {16'd5, 16'd3}) begin
      bad_n++;
      $display("FAIL stats_counts got %0d/%0d want 5/3", done0_cnt, done1_cnt);
    end
    cmp_n++;
    if (wr_tag.size() - w0 !== 8) begin
      bad_n++;
      $display("FAIL stats_writes got %0d want 8", wr_tag.size() - w0);
    end
    for (int i = w0; i < wr_tag.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 9'bx;
      cmp_n++;
      if ({wr_tag[i], wr_data[i]} !== e) begin
        bad_n++;
        $display("FAIL stats_data got %h want %h", {wr_tag[i], wr_data[i]}, e);
      end
    end
    exp_q.delete();
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    cmp_n++;
    if ({done0_cnt, done1_cnt} !== 32'h0) begin
      bad_n++;
      $display("FAIL stats_reset got %0d/%0d want 0/0", done0_cnt, done1_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req0_op = '0;
    req1_a = '0;
    req1_b = '0;
    req1_op = '0;
    fifo_full = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_reset_mid;
    test_lone_fairness;
`ifdef ALU_SCHED_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
